// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_e    : fetch FSM states (IDLE / REQ / DRAIN)
//   INST_W           : instruction word width
//   DEFAULT_RESET_PC : default first fetch address after reset
//   word_align()     : clears the byte-offset bits of an address
package ifetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: prefetch buffer of DEPTH entries, each W bits ({pc, inst}).
// Ports:
//   clock, reset      : clock, asynchronous active-low reset
//   push_i / wdata_i  : write one entry at the tail
//   pop_i             : remove the head entry
//   flush_i           : empty the buffer; overrides push and pop
//   rdata_o           : head entry (don't-care while count_o == 0)
//   count_o           : number of valid entries
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: entries are only observed through count_q.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction prefetcher with a DEPTH-entry buffer.
// Ports:
//   clock, reset              : clock, asynchronous active-low reset
//   mem_req, mem_addr         : fetch request / word address to instruction memory
//   mem_ack, mem_rdata        : memory accepts the request and returns data in the same cycle
//   inst_valid, inst, inst_pc : buffer head presented to the consumer
//   inst_ready                : consumer takes the head this cycle
//   redirect, redirect_pc     : discard prefetched work, restart fetching at redirect_pc
//   dbg_state                 : current FSM state, for observation only
//   flush_cnt                 : saturating redirect counter (only with IFETCH_FLUSH_CNT_EN)
// Build option: define IFETCH_FLUSH_CNT_EN to add the flush_cnt output and its counter.
//
// Handshakes: a memory transfer happens in a cycle where mem_req && mem_ack;
// once raised, mem_req/mem_addr hold until that cycle and mem_ack is ignored
// while mem_req is low. A consumer transfer happens where inst_valid &&
// inst_ready. A redirect cancels both transfers of its cycle.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output fetch_state_e      dbg_state
`ifdef IFETCH_FLUSH_CNT_EN
  ,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       addr_q, addr_d;
  logic              req_q, req_d;
  logic [CW-1:0]     count;
  logic [31+INST_W:0] head;
  logic              ack, push, pop;

  // Only an ack against a live request counts.
  assign ack  = req_q && mem_ack;
  assign pop  = inst_valid && inst_ready && !redirect;
  assign push = (state_q == REQ) && ack && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
          state_d    = REQ;
        end else if (count < CW'(DEPTH)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
          // Without an ack the old request is still in flight and must finish.
          state_d    = ack ? REQ : DRAIN;
        end else if (ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          // Room for another word once this push (and any pop) has landed.
          state_d    = (pop || (count < CW'(DEPTH - 1))) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (redirect) fetch_pc_d = word_align(redirect_pc);
        if (ack)      state_d    = REQ;
      end
      default: state_d = IDLE;
    endcase
    // An unacknowledged request keeps its address; otherwise follow fetch_pc.
    addr_d = (req_q && !mem_ack) ? addr_q : fetch_pc_d;
    req_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (32 + INST_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({fetch_pc_q, mem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect),
    .rdata_o (head),
    .count_o (count)
  );

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign inst_valid = (count != '0);
  assign inst       = head[INST_W-1:0];
  assign inst_pc    = head[31+INST_W:INST_W];
  assign dbg_state  = state_q;

`ifdef IFETCH_FLUSH_CNT_EN
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flush_cnt_q <= '0;
    end else if (redirect && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: self-checking bench for ifetch_unit (DEPTH=2, RESET_PC=0x3000).
// Instruction memory content is a fixed function of the word address.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_ready = 1'b0;
  logic         redirect = 1'b0;
  logic [31:0]  redirect_pc = '0;
  fetch_state_e dbg_state;
`ifdef IFETCH_FLUSH_CNT_EN
  logic [15:0]  flush_cnt;
`endif

  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dbg_state   (dbg_state)
`ifdef IFETCH_FLUSH_CNT_EN
    ,
    .flush_cnt   (flush_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ {a[7:0], a[31:8]} ^ 32'h1234_5678;
  endfunction

  // ---------------- reference model ----------------
  // Buffer contents are tracked as a queue of pcs in program order. Each memory
  // request is tagged with the redirect epoch in which it was issued; its data
  // is kept only if no redirect happened before or on its ack cycle.
  logic [31:0] exp_q[$];
  int unsigned epoch = 0;
  int unsigned req_epoch = 0;
  logic [31:0] next_fetch = RST_PC;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;
  int          idle_run = 0;
  logic [15:0] flush_exp = '0;

  task automatic monitor_step();
    logic pop, acc;
    if (!reset) begin
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, RST_PC);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
`ifdef IFETCH_FLUSH_CNT_EN
      check("rst_flush_cnt", {16'b0, flush_cnt}, 32'd0);
`endif
      exp_q.delete();
      epoch++;
      next_fetch = RST_PC;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      idle_run = 0;
      flush_exp = '0;
    end else begin
      // memory protocol
      if (prev_req && !prev_ack) begin
        check("req_hold", {31'b0, mem_req}, 32'd1);
        check("addr_hold", mem_addr, prev_addr);
      end
      check("addr_align", {30'b0, mem_addr[1:0]}, 32'd0);
      check("req_vs_state", {31'b0, mem_req}, {31'b0, dbg_state != IDLE});
      // buffer head
      check("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("inst_pc", inst_pc, exp_q[0]);
        check("inst", inst, mem_word(exp_q[0]));
      end
`ifdef IFETCH_FLUSH_CNT_EN
      check("flush_cnt", {16'b0, flush_cnt}, {16'b0, flush_exp});
`endif
      // a new request begins: it must fetch the next program-order word
      if (mem_req && (!prev_req || prev_ack)) begin
        req_epoch = epoch;
        check("fetch_addr", mem_addr, next_fetch);
      end
      // with free space the unit may idle for at most a couple of cycles
      if (!mem_req && exp_q.size() < DEPTH) idle_run++;
      else idle_run = 0;
      check("no_starve", {31'b0, idle_run > 2}, 32'd0);
      // effects of the coming edge
      pop = inst_valid && inst_ready && !redirect;
      acc = mem_req && mem_ack && !redirect && (req_epoch == epoch);
      if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(mem_addr);
        next_fetch = mem_addr + 32'd4;
      end
      if (redirect) begin
        exp_q.delete();
        epoch++;
        next_fetch = {redirect_pc[31:2], 2'b00};
        if (flush_exp != 16'hFFFF) flush_exp = flush_exp + 16'd1;
      end
      check("capacity", {31'b0, exp_q.size() <= DEPTH}, 32'd1);
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ack, input logic rdy, input logic rd, input logic [31:0] rpc);
    mem_ack     = ack;
    mem_rdata   = ack ? mem_word(mem_addr) : $urandom;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic to_neg();
    @(negedge clock);
    monitor_step();
  endtask

  task automatic to_pos();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic ack, input logic rdy, input logic rd, input logic [31:0] rpc);
    drive(ack, rdy, rd, rpc);
    to_neg();
    to_pos();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ack;
    logic        ready;
    logic        rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    // row: inputs for the cycle, then outputs expected in that cycle
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3004, 1'b1, 32'h0000_3000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3008, 1'b1, 32'h0000_3004};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_300C, 1'b1, 32'h0000_3008};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_3010, 1'b1, 32'h0000_3008};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3010, 1'b1, 32'h0000_3008};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3010, 1'b1, 32'h0000_300C};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3010, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3010, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h0000_4002, 1'b1, 32'h0000_3010, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3010, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_3010, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_4000, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_4004, 1'b1, 32'h0000_4000};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_4008, 1'b1, 32'h0000_4000};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0};

    // ---------------- reset ----------------
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      to_neg();
      to_pos();
    end
    reset = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ack, vecs[i].ready, vecs[i].rd, vecs[i].rpc);
      to_neg();
      check($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
        check($sformatf("v%0d_inst", i), inst, mem_word(vecs[i].e_pc));
      end
      if (i == 11) check("v11_drain", {30'b0, dbg_state}, {30'b0, DRAIN});
      to_pos();
    end

    // ---------------- delayed ack: three wait cycles, one push ----------------
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("slow_valid", {31'b0, inst_valid}, 32'd1);
    check("slow_pc", inst_pc, 32'h0000_0100);
    check("slow_next_addr", mem_addr, 32'h0000_0104);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("slow_single_push", {31'b0, inst_valid}, 32'd0);
`ifdef IFETCH_FLUSH_CNT_EN
    check("flush_cnt_3", {16'b0, flush_cnt}, 32'd3);
`endif

    // ---------------- reset in the middle of a request ----------------
    check("mid_req_pending", {31'b0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_addr", mem_addr, RST_PC);
    check("mid_rst_valid", {31'b0, inst_valid}, 32'd0);
    check("mid_rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
`ifdef IFETCH_FLUSH_CNT_EN
    check("mid_rst_flush_cnt", {16'b0, flush_cnt}, 32'd0);
`endif
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("rel_req_low", {31'b0, mem_req}, 32'd0);
    to_neg();
    to_pos();
    check("rel_req_rise", {31'b0, mem_req}, 32'd1);
    check("rel_addr", mem_addr, RST_PC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rel_first_pc", inst_pc, RST_PC);
    check("rel_first_valid", {31'b0, inst_valid}, 32'd1);

    // ---------------- randomized traffic against the model ----------------
    for (int n = 0; n < 4000; n++) begin
      logic        ack, rdy, rd;
      logic [31:0] rpc;
      ack = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      step(ack, rdy, rd, rpc);
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter DEPTH, default 2, prefetch buffer entries (legal values 1..8).
REQ-002 Parameter RESET_PC, default 32'h0000_3000, first fetch address after reset.
REQ-003 Port clock, in, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset, in, 1, asynchronous active-low reset.
REQ-005 Port mem_req, out, 1, fetch request to instruction memory.
REQ-006 Port mem_addr, out, 32, word address of the request; bits [1:0] always 0.
REQ-007 Port mem_ack, in, 1, memory accepts the request and returns data this cycle.
REQ-008 Port mem_rdata, in, 32, instruction word; valid only while mem_ack=1.
REQ-009 Port inst_valid, out, 1, buffer head holds a valid instruction.
REQ-010 Port inst, out, 32, instruction at the buffer head.
REQ-011 Port inst_pc, out, 32, address of inst.
REQ-012 Port inst_ready, in, 1, consumer (decode/datapath) takes the head this cycle.
REQ-013 Port redirect, in, 1, discard prefetched work and fetch from redirect_pc.
REQ-014 Port redirect_pc, in, 32, new fetch address; bits [1:0] ignored (treated as 0).

Function
REQ-015 The FSM SHALL have states IDLE, REQ and DRAIN; mem_req = 1 exactly in REQ and DRAIN.
REQ-016 mem_req and mem_addr SHALL be held stable from assertion until the cycle mem_ack=1.
REQ-017 At most one request SHALL be outstanding; mem_ack while mem_req=0 SHALL be ignored.
REQ-018 IDLE->REQ SHALL occur at an edge where entries+pending < DEPTH (space reserved before issue).
REQ-019 In REQ with mem_ack=1 and no redirect: push {fetch_pc, mem_rdata}, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), stay REQ if space remains after the concurrent push/pop, else go IDLE.
REQ-020 Zero-wait memory (mem_ack tied 1) SHALL yield one instruction per cycle while inst_ready=1.
REQ-021 inst_valid = (count != 0); pop SHALL occur iff inst_valid && inst_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-022 inst/inst_pc SHALL be the FIFO head, in program order; values while inst_valid=0 are don't-care.
REQ-023 redirect=1 SHALL empty the buffer at that edge (inst_valid=0 next cycle), discard any same-cycle pop and push, and load fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-024 redirect in REQ without mem_ack SHALL go to DRAIN; the outstanding request completes, its data is dropped, then the FSM goes to REQ at the new fetch_pc.
REQ-025 redirect in REQ with mem_ack, or in IDLE, SHALL go to REQ at the new fetch_pc.
REQ-026 redirect in DRAIN SHALL update fetch_pc and remain in DRAIN (last target wins).

Reset
REQ-027 While reset=0: state IDLE, fetch_pc = RESET_PC, count 0, mem_req 0, mem_addr RESET_PC, inst_valid 0.
REQ-028 Reset asserted mid-request SHALL abandon it immediately; no data from it is ever pushed.
REQ-029 First rising edge after release SHALL move IDLE->REQ (mem_req=1 one cycle after release).

Configuration
REQ-030 Macro IFETCH_FLUSH_CNT_EN defined: extra output flush_cnt, 16 bits, incremented on every redirect edge, saturating at 16'hFFFF, reset to 0.
REQ-031 Macro undefined: no flush_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-032 Package ifetch_pkg SHALL hold the state enum (IDLE/REQ/DRAIN), INST_W=32, default RESET_PC.
REQ-033 The buffer SHALL be sub-module ifetch_fifo (DEPTH x 64 bits {pc,inst}, push/pop/flush, count).

Verification
REQ-034 Reset release, mem_ack=1, inst_ready=1 -> mem_req rises cycle 1; inst_pc 0x3000,0x3004,0x3008 on consecutive cycles.
REQ-035 inst_ready=0, DEPTH=2, mem_ack=1 -> two pushes then mem_req=0; inst_ready=1 -> fetch resumes at 0x3008, no word lost or duplicated.
REQ-036 mem_ack delayed 3 cycles -> mem_req/mem_addr stable throughout; single push on ack cycle.
REQ-037 redirect to 0x4002 while request to 0x3004 outstanding -> DRAIN, 0x3004 data dropped, next inst_pc 0x4000.
REQ-038 fetch_pc 0xFFFF_FFFC acked -> next mem_addr 0x0000_0000.
REQ-039 With IFETCH_FLUSH_CNT_EN, 3 redirects -> flush_cnt=3; reset=0 mid-request -> all outputs at reset values same cycle.
